// File: rtl/pattern_match_periph_if.sv
// CPU-to-peripheral data bus: byte address, write data/enables, combinational read data,
// and the registered match pulse.
interface pattern_match_periph_if;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic        match;

   modport master (output daddr, output dwdata, output dwe, input drdata, input match);
   modport slave  (input daddr, input dwdata, input dwe, output drdata, output match);
endinterface

// File: rtl/pattern_match_periph.sv
// Pattern matching peripheral: a 1-4 byte pattern is matched (overlapping) against text
// words streamed through a FIFO, scanning one byte per cycle.
module pattern_match_periph #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   pattern_match_periph_if.slave   bus
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {ST_IDLE, ST_SCAN} state_e;

   state_e         state_q, state_d;
   logic [31:0]    pattern_q, pattern_d;
   logic           en_q, en_d;
   logic [1:0]     plen_q, plen_d;
   logic [31:0]    mem_q [FIFO_DEPTH];
   logic [31:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  fcnt_q, fcnt_d;
   logic           ovf_q, ovf_d;
   logic [31:0]    count_q, count_d;
   logic [31:0]    hist_q, hist_d;
   logic [2:0]     vcnt_q, vcnt_d;
   logic [1:0]     idx_q, idx_d;
   logic [31:0]    w_q, w_d;
   logic           match_q, match_d;

   logic           sel_c, wr_pat_c, wr_ctrl_c, push_req_c, wr_cnt_c, clr_c;
   logic [2:0]     off_c;
   logic           empty_c, full_c, push_c, pop_c, scan_c, match_c, cmp_c;
   logic [7:0]     byte_c;
   logic [31:0]    hist_new_c;
   logic [2:0]     vcnt_new_c, plen_len_c;
   logic           unused_ok;

   assign unused_ok = ^bus.daddr[1:0];

   // Address decode and write strobes
   always_comb begin
      sel_c      = (bus.daddr[31:5] == BASE_ADDR[31:5]);
      off_c      = bus.daddr[4:2];
      wr_pat_c   = sel_c && (off_c == 3'd0) && (bus.dwe != 4'h0);
      wr_ctrl_c  = sel_c && (off_c == 3'd1) && (bus.dwe != 4'h0);
      push_req_c = sel_c && (off_c == 3'd2) && (bus.dwe == 4'hF);
      wr_cnt_c   = sel_c && (off_c == 3'd4) && (bus.dwe != 4'h0);
      clr_c      = wr_ctrl_c && bus.dwdata[1];
      empty_c    = (fcnt_q == '0);
      full_c     = (fcnt_q == CW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (en_q && !empty_c) state_d = ST_SCAN;
         ST_SCAN: if ((idx_q == 2'd3) && !(en_q && !empty_c)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (clr_c) state_d = ST_IDLE;
   end

   always_comb begin
      pop_c  = 1'b0;
      scan_c = 1'b0;
      unique case (state_q)
         ST_IDLE: pop_c = en_q && !empty_c;
         ST_SCAN: begin
            scan_c = 1'b1;
            pop_c  = (idx_q == 2'd3) && en_q && !empty_c;
         end
         default: ;
      endcase
      if (clr_c) pop_c = 1'b0;
   end

   // Byte scan: the newest history byte lines up with the last pattern character
   always_comb begin
      byte_c     = w_q[{idx_q, 3'b000} +: 8];
      hist_new_c = {hist_q[23:0], byte_c};
      vcnt_new_c = (vcnt_q == 3'd4) ? 3'd4 : vcnt_q + 3'd1;
      plen_len_c = {1'b0, plen_q} + 3'd1;
      unique case (plen_q)
         2'd0: cmp_c = (hist_new_c[7:0]  == pattern_q[7:0]);
         2'd1: cmp_c = (hist_new_c[15:0] == {pattern_q[7:0], pattern_q[15:8]});
         2'd2: cmp_c = (hist_new_c[23:0] == {pattern_q[7:0], pattern_q[15:8], pattern_q[23:16]});
         default: cmp_c = (hist_new_c == {pattern_q[7:0], pattern_q[15:8],
                                          pattern_q[23:16], pattern_q[31:24]});
      endcase
      match_c = scan_c && (vcnt_new_c >= plen_len_c) && cmp_c;
   end

   always_comb begin
      pattern_d = pattern_q;
      en_d      = en_q;
      plen_d    = plen_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      hist_d    = hist_q;
      vcnt_d    = vcnt_q;
      idx_d     = idx_q;
      w_d       = w_q;
      match_d   = match_c;
      count_d   = count_q + 32'(match_c);
      push_c    = push_req_c && !full_c && !clr_c;

      for (int k = 0; k < 4; k++)
         if (wr_pat_c && bus.dwe[k]) pattern_d[8*k +: 8] = bus.dwdata[8*k +: 8];
      if (wr_ctrl_c) begin
         en_d   = bus.dwdata[0];
         plen_d = bus.dwdata[3:2];
      end
      if (push_c) begin
         mem_d[wr_ptr_q] = bus.dwdata;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (push_req_c && full_c) ovf_d = 1'b1;
      if (scan_c) begin
         hist_d = hist_new_c;
         vcnt_d = vcnt_new_c;
         idx_d  = idx_q + 2'd1;
      end
      if (pop_c) begin
         w_d      = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
         idx_d    = 2'd0;
      end
      fcnt_d = fcnt_q + CW'(push_c) - CW'(pop_c);
      if (wr_cnt_c) count_d = '0;

      // Clear overrides every other update except the CTRL fields written alongside it
      if (clr_c) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fcnt_d   = '0;
         ovf_d    = 1'b0;
         count_d  = '0;
         hist_d   = '0;
         vcnt_d   = '0;
         idx_d    = '0;
         match_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern_q <= '0;
         en_q      <= 1'b0;
         plen_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         ovf_q     <= 1'b0;
         count_q   <= '0;
         hist_q    <= '0;
         vcnt_q    <= '0;
         idx_q     <= '0;
         w_q       <= '0;
         match_q   <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         en_q      <= en_d;
         plen_q    <= plen_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fcnt_q    <= fcnt_d;
         ovf_q     <= ovf_d;
         count_q   <= count_d;
         hist_q    <= hist_d;
         vcnt_q    <= vcnt_d;
         idx_q     <= idx_d;
         w_q       <= w_d;
         match_q   <= match_d;
      end
   end

   // Combinational read port
   always_comb begin
      bus.drdata = '0;
      if (sel_c) begin
         unique case (off_c)
            3'd0: bus.drdata = pattern_q;
            3'd1: bus.drdata = {28'b0, plen_q, 1'b0, en_q};
            3'd3: bus.drdata = {16'b0, 8'(fcnt_q), 4'b0, ovf_q, full_c, empty_c,
                                (state_q != ST_IDLE)};
            3'd4: bus.drdata = count_q;
            default: bus.drdata = '0;
         endcase
      end
   end

   assign bus.match = match_q;

endmodule

// File: tb/tb_pattern_match_periph.sv
// Randomized bench for pattern_match_periph against a queue-based model of the
// FIFO, byte stream and match history.
module tb_pattern_match_periph;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic clk;
   logic reset;
   pattern_match_periph_if bus ();

   pattern_match_periph #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;

   // Reference model state
   logic [31:0] m_pat;
   logic        m_en;
   int          m_plen;
   logic [31:0] m_fifo [$];
   logic [7:0]  m_cur  [$];
   logic [7:0]  m_hist [$];
   logic [31:0] m_cnt;
   logic        m_ovf;
   logic        m_match;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_pat = '0; m_en = 1'b0; m_plen = 1;
      m_fifo.delete(); m_cur.delete(); m_hist.delete();
      m_cnt = '0; m_ovf = 1'b0; m_match = 1'b0;
   endtask

   task automatic m_load();
      logic [31:0] w;
      w = m_fifo.pop_front();
      for (int k = 0; k < 4; k++) m_cur.push_back(w[8*k +: 8]);
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      r = '0;
      if (a[31:5] == BASE[31:5]) begin
         case (a[4:2])
            3'd0: r = m_pat;
            3'd1: r = {28'b0, 2'(m_plen - 1), 1'b0, m_en};
            3'd3: r = {16'b0, 8'(m_fifo.size()), 4'b0, m_ovf,
                       (m_fifo.size() == DEPTH), (m_fifo.size() == 0), (m_cur.size() != 0)};
            3'd4: r = m_cnt;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // One clock edge of the model with the given bus write
   task automatic m_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      logic sel, full_old, ok;
      logic [2:0] off;
      sel = (a[31:5] == BASE[31:5]);
      off = a[4:2];
      full_old = (m_fifo.size() == DEPTH);
      m_match = 1'b0;
      if (m_cur.size() != 0) begin
         m_hist.push_back(m_cur.pop_front());
         if (m_hist.size() > 4) void'(m_hist.pop_front());
         if (m_hist.size() >= m_plen) begin
            ok = 1'b1;
            for (int i = 0; i < m_plen; i++)
               if (m_hist[m_hist.size() - m_plen + i] != m_pat[8*i +: 8]) ok = 1'b0;
            if (ok) begin
               m_match = 1'b1;
               m_cnt++;
            end
         end
         if (m_cur.size() == 0 && m_en && m_fifo.size() != 0) m_load();
      end else if (m_en && m_fifo.size() != 0) begin
         m_load();
      end
      if (sel && off == 3'd2 && we == 4'hF) begin
         if (full_old) m_ovf = 1'b1;
         else          m_fifo.push_back(d);
      end
      if (sel && off == 3'd4 && we != 4'h0) m_cnt = '0;
      if (sel && off == 3'd0)
         for (int k = 0; k < 4; k++) if (we[k]) m_pat[8*k +: 8] = d[8*k +: 8];
      if (sel && off == 3'd1 && we != 4'h0) begin
         m_en   = d[0];
         m_plen = int'(d[3:2]) + 1;
         if (d[1]) begin
            m_fifo.delete(); m_cur.delete(); m_hist.delete();
            m_cnt = '0; m_ovf = 1'b0; m_match = 1'b0;
         end
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = ($urandom_range(0, 1) != 0) ? 8'h61 : 8'h62;
      return w;
   endfunction

   function automatic logic [31:0] rand_raddr();
      logic [31:0] a;
      a = BASE + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 32'h0080_0000 + 32'(4 * $urandom_range(0, 4));
      return a;
   endfunction

   // One clock: check a random read, apply a write, check the match pulse
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      logic [31:0] ra;
      ra = rand_raddr();
      bus.daddr = ra; bus.dwe = 4'h0;
      #1;
      check_eq("rand_read", bus.drdata, m_read(ra));
      bus.daddr = a; bus.dwdata = d; bus.dwe = we;
      @(posedge clk);
      m_step(a, d, we);
      #1;
      check_eq("match", {31'b0, bus.match}, {31'b0, m_match});
      if (bus.match) pulses++;
      bus.daddr = '0; bus.dwe = 4'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(32'h0, 32'h0, 4'h0);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.daddr = a; bus.dwe = 4'h0;
      #1;
      check_eq(tag, bus.drdata, exp);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0]  we;
      int r;

      bus.daddr = '0; bus.dwdata = '0; bus.dwe = 4'h0;
      reset = 1'b1;
      m_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      m_step(32'h0, 32'h0, 4'h0);
      #1;

      rd_chk("rst_pattern", BASE + 32'h00, 32'h0);
      rd_chk("rst_ctrl",    BASE + 32'h04, 32'h0);
      rd_chk("rst_data",    BASE + 32'h08, 32'h0);
      rd_chk("rst_status",  BASE + 32'h0C, 32'h2);
      rd_chk("rst_count",   BASE + 32'h10, 32'h0);
      idle(1);
      rd_chk("rd_off5",     BASE + 32'h14, 32'h0);
      rd_chk("rd_outside",  32'h0080_0000, 32'h0);

      // "ab", PLEN 2: two matches, final count exactly five edges after the DATA write
      cyc(BASE + 32'h00, 32'h0000_6261, 4'hF);
      cyc(BASE + 32'h04, 32'h0000_0005, 4'hF);
      pulses = 0;
      cyc(BASE + 32'h08, 32'h6261_6261, 4'hF);
      idle(4);
      rd_chk("lat_count4", BASE + 32'h10, 32'd1);
      idle(1);
      rd_chk("lat_count5", BASE + 32'h10, 32'd2);
      check_eq("lat_pulses", 32'(pulses), 32'd2);

      // "aba", PLEN 3, overlapping match across a word boundary
      cyc(BASE + 32'h10, 32'h0, 4'hF);
      cyc(BASE + 32'h00, 32'h0061_6261, 4'hF);
      cyc(BASE + 32'h04, 32'h0000_000B, 4'hF);
      cyc(BASE + 32'h08, 32'h6162_6162, 4'hF);
      cyc(BASE + 32'h08, 32'h0000_6162, 4'hF);
      idle(12);
      rd_chk("overlap_count", BASE + 32'h10, 32'd2);

      // Overflow with scanning disabled, then drain
      cyc(BASE + 32'h04, 32'h0000_0008, 4'hF);
      for (int i = 0; i < 9; i++) cyc(BASE + 32'h08, rand_word(), 4'hF);
      rd_chk("ovf_status", BASE + 32'h0C, 32'h0000_080C);
      cyc(BASE + 32'h04, 32'h0000_0009, 4'hF);
      idle(40);
      rd_chk("drain_status", BASE + 32'h0C, 32'h0000_000A);
      cyc(BASE + 32'h04, 32'h0000_000B, 4'hF);
      rd_chk("clr_ovf_status", BASE + 32'h0C, 32'h0000_0002);

      // CLR while scanning with three words queued
      cyc(BASE + 32'h04, 32'h0000_0001, 4'hF);
      for (int i = 0; i < 4; i++) cyc(BASE + 32'h08, rand_word(), 4'hF);
      cyc(BASE + 32'h04, 32'h0000_0002, 4'hF);
      check_eq("clr_match", {31'b0, bus.match}, 32'h0);
      rd_chk("clr_status", BASE + 32'h0C, 32'h0000_0002);
      rd_chk("clr_count",  BASE + 32'h10, 32'h0);

      // Partial byte enables
      cyc(BASE + 32'h00, 32'h0, 4'hF);
      cyc(BASE + 32'h08, 32'h1234_5678, 4'b0011);
      rd_chk("partial_data_status", BASE + 32'h0C, 32'h0000_0002);
      cyc(BASE + 32'h00, 32'hFFFF_FF41, 4'b0001);
      rd_chk("partial_pattern", BASE + 32'h00, 32'h0000_0041);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         a = '0; d = '0; we = 4'h0;
         if (r < 35) begin
            a = BASE + 32'h08; d = rand_word();
            we = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
         end else if (r < 45) begin
            a = BASE + 32'h04;
            d = ($urandom & 32'hFFFF_FFF0) | {28'b0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0)};
            we = 4'($urandom_range(1, 15));
         end else if (r < 55) begin
            a = BASE + 32'h00; d = rand_word(); we = 4'($urandom_range(1, 15));
         end else if (r < 60) begin
            a = BASE + 32'h10; d = $urandom; we = 4'($urandom_range(1, 15));
         end else if (r < 64) begin
            a = ($urandom_range(0, 1) != 0) ? BASE + 32'(4 * $urandom_range(5, 7))
                                            : 32'h0080_0000 + 32'(4 * $urandom_range(0, 4));
            d = $urandom; we = 4'($urandom_range(1, 15));
         end
         cyc(a, d, we);
      end
      rd_chk("final_count",  BASE + 32'h10, m_cnt);
      rd_chk("final_status", BASE + 32'h0C, m_read(BASE + 32'h0C));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
